// File: rtl/imem_fetch_bridge.sv
// imem_fetch_bridge: serves the fetch stage's single-outstanding instruction
// request by reading each instruction as two bus-width halves (low half at the
// even word address, then high half) over a Wishbone-style classic read bus.
// Bus errors are retried a bounded number of times per half; exhausting the
// retries completes the request with a NOP (all zeros) and sets a sticky fault.
module imem_fetch_bridge #(
  parameter int                RW        = 16,
  parameter int                I_SIZE    = 32,
  parameter int                BUS_DW    = 16,
  parameter int                BUS_AW    = 24,
  parameter logic [BUS_AW-1:0] IMEM_BASE = '0,
  parameter int                MAX_RETRY = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [RW-1:0]     i_req_addr,
  input  logic              i_req_active,
  output logic [I_SIZE-1:0] o_req_data,
  output logic              o_req_data_valid,
  output logic              o_bus_cyc,
  output logic              o_bus_stb,
  output logic [BUS_AW-1:0] o_bus_adr,
  input  logic [BUS_DW-1:0] i_bus_data,
  input  logic              i_bus_ack,
  input  logic              i_bus_err,
  output logic              o_fault
);

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, RESP} state_t;

  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_t            state, state_next;
  logic              cyc_next, stb_next;
  logic [BUS_AW-1:0] adr_next;
  logic [BUS_DW-1:0] lo_half, lo_half_next;
  logic [I_SIZE-1:0] data_next;
  logic              valid_next, fault_next;
  logic [3:0]        retry, retry_next;
  logic [BUS_AW-1:0] base_adr;

  // Each instruction occupies two bus words, so the instruction index is doubled.
  assign base_adr = IMEM_BASE + BUS_AW'({i_req_addr, 1'b0});

  // State and registered outputs; everything is loaded from the next-state logic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      o_bus_cyc        <= 1'b0;
      o_bus_stb        <= 1'b0;
      o_bus_adr        <= '0;
      lo_half          <= '0;
      o_req_data       <= '0;
      o_req_data_valid <= 1'b0;
      o_fault          <= 1'b0;
      retry            <= '0;
    end else begin
      state            <= state_next;
      o_bus_cyc        <= cyc_next;
      o_bus_stb        <= stb_next;
      o_bus_adr        <= adr_next;
      lo_half          <= lo_half_next;
      o_req_data       <= data_next;
      o_req_data_valid <= valid_next;
      o_fault          <= fault_next;
      retry            <= retry_next;
    end
  end

  // Next-state and next-output logic; a low stb while in a read state marks the
  // one-cycle gap after a bus error, after which the same half is re-strobed.
  always_comb begin
    state_next   = state;
    cyc_next     = o_bus_cyc;
    stb_next     = o_bus_stb;
    adr_next     = o_bus_adr;
    lo_half_next = lo_half;
    data_next    = o_req_data;
    valid_next   = 1'b0;
    fault_next   = o_fault;
    retry_next   = retry;

    case (state)
      IDLE: begin
        cyc_next = 1'b0;
        stb_next = 1'b0;
        if (i_req_active) begin
          adr_next   = base_adr;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          retry_next = '0;
          state_next = RD_LO;
        end
      end

      RD_LO, RD_HI: begin
        if (!o_bus_stb) begin
          stb_next = 1'b1;
        end else if (i_bus_err) begin
          if (retry == RETRY_LIMIT) begin
            fault_next = 1'b1;
            data_next  = '0;
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
            valid_next = 1'b1;
            state_next = RESP;
          end else begin
            retry_next = retry + 4'd1;
            stb_next   = 1'b0;
          end
        end else if (i_bus_ack) begin
          if (state == RD_LO) begin
            lo_half_next = i_bus_data;
            adr_next     = o_bus_adr + BUS_AW'(1);
            retry_next   = '0;
            state_next   = RD_HI;
          end else begin
            data_next  = {i_bus_data, lo_half};
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
            valid_next = 1'b1;
            state_next = RESP;
          end
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_fetch_bridge.sv
// tb_imem_fetch_bridge: drives the fetch bridge against a scripted bus slave,
// using a table of directed transactions, hand-written reset and back-to-back
// sequences, and randomized transactions checked against a per-request model.
module tb_imem_fetch_bridge;

  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req_addr = '0;
  logic        req_active = 1'b0;
  logic [15:0] bus_data = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;

  logic [31:0] req_data, req_data_b;
  logic        req_valid, req_valid_b;
  logic        bus_cyc, bus_cyc_b, bus_stb, bus_stb_b;
  logic [23:0] bus_adr, bus_adr_b;
  logic        fault, fault_b;

  int testsRun = 0;
  int failures = 0;

  // Bus slave configuration, set by the stimulus tasks while the bridge is idle.
  int          waitCfg = 0;
  bit          randWait = 1'b0;
  int          curRand = 0;
  int          waitCnt = 0;
  int          errLoLeft = 0;
  int          errHiLeft = 0;
  bit          useFixed = 1'b0;
  logic [15:0] fixedLo = '0, fixedHi = '0;
  logic [23:0] respLog[$];

  imem_fetch_bridge dut (
    .i_clk(clk), .i_rst(rst), .i_req_addr(req_addr), .i_req_active(req_active),
    .o_req_data(req_data), .o_req_data_valid(req_valid),
    .o_bus_cyc(bus_cyc), .o_bus_stb(bus_stb), .o_bus_adr(bus_adr),
    .i_bus_data(bus_data), .i_bus_ack(bus_ack), .i_bus_err(bus_err),
    .o_fault(fault)
  );

  imem_fetch_bridge #(.IMEM_BASE(24'h100000)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_addr(req_addr), .i_req_active(req_active),
    .o_req_data(req_data_b), .o_req_data_valid(req_valid_b),
    .o_bus_cyc(bus_cyc_b), .o_bus_stb(bus_stb_b), .o_bus_adr(bus_adr_b),
    .i_bus_data(bus_data), .i_bus_ack(bus_ack), .i_bus_err(bus_err),
    .o_fault(fault_b)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [23:0] a);
    return {a[7:0], a[15:8]} ^ a[23:8] ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] wordAt(input logic [23:0] a);
    if (useFixed) return a[0] ? fixedHi : fixedLo;
    return memWord(a);
  endfunction

  // Scripted slave: answers each strobe after the configured wait, injecting
  // the planned number of errors per half before acknowledging.
  always @(negedge clk) begin
    bus_ack = 1'b0;
    bus_err = 1'b0;
    if (bus_cyc && bus_stb && !rst) begin
      if (waitCnt >= (randWait ? curRand : waitCfg)) begin
        waitCnt = 0;
        respLog.push_back(bus_adr);
        if (!bus_adr[0] && errLoLeft > 0) begin
          bus_err = 1'b1;
          errLoLeft--;
        end else if (bus_adr[0] && errHiLeft > 0) begin
          bus_err = 1'b1;
          errHiLeft--;
        end else begin
          bus_ack  = 1'b1;
          bus_data = wordAt(bus_adr);
        end
        curRand = $urandom_range(0, 2);
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one request from an idle bridge and measures what came back.
  task automatic applyStimulus(input logic [15:0] addr, input int w, input bit rw,
                               input int eL, input int eH,
                               output logic [31:0] data, output int lat, output int cycCnt,
                               output int nLo, output int nHi, output bit addrBad,
                               output bit timedOut);
    logic [23:0] base;
    bit sawHi;
    @(negedge clk);
    base = {7'b0, addr, 1'b0};
    waitCfg = w; randWait = rw; errLoLeft = eL; errHiLeft = eH;
    respLog.delete();
    req_addr = addr;
    req_active = 1'b1;
    lat = 1; cycCnt = 0; addrBad = 1'b0; timedOut = 1'b1; sawHi = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req_active = 1'b0;
      req_addr = 16'($urandom);
      lat++;
      if (bus_cyc) cycCnt++;
      if (bus_stb) begin
        if (bus_adr == base + 24'd1) sawHi = 1'b1;
        else if (bus_adr != base || sawHi) addrBad = 1'b1;
        if (bus_adr_b != bus_adr + 24'h100000) addrBad = 1'b1;
      end
      if ({bus_cyc_b, bus_stb_b, req_valid_b, fault_b, req_data_b} !==
          {bus_cyc, bus_stb, req_valid, fault, req_data}) addrBad = 1'b1;
      if (req_valid) begin
        timedOut = 1'b0;
        break;
      end
    end
    data = req_data;
    nLo = 0; nHi = 0;
    foreach (respLog[k]) begin
      if (respLog[k] == base) nLo++;
      else if (respLog[k] == base + 24'd1) nHi++;
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] lo;
    logic [15:0] hi;
    int          w;
    int          eL;
    int          eH;
    logic [31:0] expData;
    int          expLat;
    bit          expFault;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    logic [31:0] data, held;
    int          lat, cycCnt, nLo, nHi, expLo, expHi;
    bit          addrBad, timedOut, found, faultExp, fLo, fHi;
    logic [15:0] a;
    int          gap, pulses;

    vecs[0] = '{16'h0000, 16'h1234, 16'hABCD, 0, 0, 0, 32'hABCD1234, 4,  1'b0};
    vecs[1] = '{16'h0005, 16'h0F0F, 16'h1357, 3, 0, 0, 32'h13570F0F, 10, 1'b0};
    vecs[2] = '{16'h7FFF, 16'hBEEF, 16'hDEAD, 1, 2, 0, 32'hDEADBEEF, 12, 1'b0};
    vecs[3] = '{16'h0003, 16'h5555, 16'hAAAA, 0, 0, 1, 32'hAAAA5555, 6,  1'b0};
    vecs[4] = '{16'h0009, 16'h1111, 16'h2222, 0, 0, 3, 32'h22221111, 10, 1'b0};
    vecs[5] = '{16'h0002, 16'h7777, 16'h8888, 0, 4, 0, 32'h00000000, 9,  1'b1};
    vecs[6] = '{16'h0006, 16'h9999, 16'h6666, 0, 0, 4, 32'h00000000, 10, 1'b1};
    vecs[7] = '{16'h0004, 16'hCAFE, 16'hF00D, 0, 0, 0, 32'hF00DCAFE, 4,  1'b1};

    repeat (2) @(negedge clk);
    checkOutput("reset cyc",   {31'b0, bus_cyc},   0);
    checkOutput("reset stb",   {31'b0, bus_stb},   0);
    checkOutput("reset adr",   {8'b0, bus_adr},    0);
    checkOutput("reset data",  req_data,           0);
    checkOutput("reset valid", {31'b0, req_valid}, 0);
    checkOutput("reset fault", {31'b0, fault},     0);
    rst = 1'b0;

    useFixed = 1'b1;
    foreach (vecs[i]) begin
      fixedLo = vecs[i].lo;
      fixedHi = vecs[i].hi;
      applyStimulus(vecs[i].addr, vecs[i].w, 1'b0, vecs[i].eL, vecs[i].eH,
                    data, lat, cycCnt, nLo, nHi, addrBad, timedOut);
      expLo = (vecs[i].eL > MAXR) ? MAXR + 1 : vecs[i].eL + 1;
      expHi = (vecs[i].eL > MAXR) ? 0 : ((vecs[i].eH > MAXR) ? MAXR + 1 : vecs[i].eH + 1);
      checkOutput($sformatf("vec%0d timeout", i), {31'b0, timedOut}, 0);
      checkOutput($sformatf("vec%0d data", i), data, vecs[i].expData);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("vec%0d cyc cycles", i), cycCnt, vecs[i].expLat - 2);
      checkOutput($sformatf("vec%0d fault", i), {31'b0, fault}, {31'b0, vecs[i].expFault});
      checkOutput($sformatf("vec%0d lo strobes", i), nLo, expLo);
      checkOutput($sformatf("vec%0d hi strobes", i), nHi, expHi);
      checkOutput($sformatf("vec%0d bus addr", i), {31'b0, addrBad}, 0);
      held = data;
      @(negedge clk);
      checkOutput($sformatf("vec%0d pulse width", i), {31'b0, req_valid}, 0);
      checkOutput($sformatf("vec%0d data hold", i), req_data, held);
    end

    // Reset while the high half is waiting on a slow bus.
    @(negedge clk);
    waitCfg = 4; randWait = 1'b0; errLoLeft = 0; errHiLeft = 0;
    req_addr = 16'h0008;
    req_active = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      req_active = 1'b0;
      if (bus_stb && bus_adr == 24'h000011) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reset test reached hi", {31'b0, found}, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset cyc",   {31'b0, bus_cyc},   0);
    checkOutput("midreset stb",   {31'b0, bus_stb},   0);
    checkOutput("midreset adr",   {8'b0, bus_adr},    0);
    checkOutput("midreset valid", {31'b0, req_valid}, 0);
    checkOutput("midreset data",  req_data,           0);
    checkOutput("midreset fault", {31'b0, fault},     0);
    rst = 1'b0;
    fixedLo = 16'h0101; fixedHi = 16'h0202;
    applyStimulus(16'h0001, 0, 1'b0, 0, 0, data, lat, cycCnt, nLo, nHi, addrBad, timedOut);
    checkOutput("post reset data",    data, 32'h02020101);
    checkOutput("post reset latency", lat, 4);
    checkOutput("post reset fault",   {31'b0, fault}, 0);
    checkOutput("post reset lo strobes", nLo, 1);

    // Back-to-back: fetch keeps requesting and advances its address on each pulse.
    useFixed = 1'b0;
    @(negedge clk);
    waitCfg = 0; randWait = 1'b0; errLoLeft = 0; errHiLeft = 0;
    respLog.delete();
    a = 16'h0000;
    req_addr = a;
    req_active = 1'b1;
    gap = 0; pulses = 0;
    for (int i = 0; i < 100 && pulses < 3; i++) begin
      @(negedge clk);
      gap++;
      if (req_valid) begin
        checkOutput($sformatf("b2b data %0d", pulses), req_data,
                    {memWord({7'b0, a, 1'b1}), memWord({7'b0, a, 1'b0})});
        if (pulses > 0) checkOutput($sformatf("b2b spacing %0d", pulses), gap, 4);
        gap = 0;
        pulses++;
        a = a + 16'd1;
        req_addr = a;
        if (pulses == 3) req_active = 1'b0;
      end
    end
    req_active = 1'b0;
    checkOutput("b2b pulses", pulses, 3);
    checkOutput("b2b bus count", respLog.size(), 6);
    for (int k = 0; k < 6 && k < respLog.size(); k++)
      checkOutput($sformatf("b2b bus adr %0d", k), {8'b0, respLog[k]}, k);
    repeat (2) @(negedge clk);

    // Randomized requests against the per-request model.
    faultExp = 1'b0;
    for (int n = 0; n < 30; n++) begin
      int eL, eH;
      logic [23:0] base;
      logic [31:0] expData;
      a  = 16'($urandom);
      eL = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAXR + 1)) : 0;
      eH = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAXR + 1)) : 0;
      applyStimulus(a, 0, 1'b1, eL, eH, data, lat, cycCnt, nLo, nHi, addrBad, timedOut);
      base = {7'b0, a, 1'b0};
      fLo = (eL > MAXR);
      fHi = !fLo && (eH > MAXR);
      faultExp = faultExp | fLo | fHi;
      expData = (fLo || fHi) ? 32'h0 : {memWord(base + 24'd1), memWord(base)};
      expLo = fLo ? MAXR + 1 : eL + 1;
      expHi = fLo ? 0 : (fHi ? MAXR + 1 : eH + 1);
      checkOutput($sformatf("rand%0d timeout", n), {31'b0, timedOut}, 0);
      checkOutput($sformatf("rand%0d data", n), data, expData);
      checkOutput($sformatf("rand%0d fault", n), {31'b0, fault}, {31'b0, faultExp});
      checkOutput($sformatf("rand%0d lo strobes", n), nLo, expLo);
      checkOutput($sformatf("rand%0d hi strobes", n), nHi, expHi);
      checkOutput($sformatf("rand%0d bus addr", n), {31'b0, addrBad}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
